// File: rtl/dram_queue_ptr_mgr_pkg.sv
// Shared types for the DRAM queue pointer manager: FSM encoding, operation codes
// and control-register bit positions.
package dram_queue_pkg;

  localparam int CTRL_QUEUE_INIT_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/dram_queue_ptr_mgr_if.sv
// Store/remove request handshake between the queue datapath (master) and the
// pointer manager (slave).
interface dram_queue_ptr_mgr_if #(
  parameter int QID_WIDTH  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
);
  logic                  wr_req;
  logic [QID_WIDTH-1:0]  wr_qid;
  logic [LEN_WIDTH-1:0]  wr_len;
  logic                  wr_ack;
  logic                  wr_drop;
  logic [ADDR_WIDTH-1:0] wr_base;

  logic                  rd_req;
  logic [QID_WIDTH-1:0]  rd_qid;
  logic [LEN_WIDTH-1:0]  rd_len;
  logic                  rd_ack;
  logic                  rd_empty;
  logic [ADDR_WIDTH-1:0] rd_base;

  modport master (
    output wr_req, wr_qid, wr_len, rd_req, rd_qid, rd_len,
    input  wr_ack, wr_drop, wr_base, rd_ack, rd_empty, rd_base
  );

  modport slave (
    input  wr_req, wr_qid, wr_len, rd_req, rd_qid, rd_len,
    output wr_ack, wr_drop, wr_base, rd_ack, rd_empty, rd_base
  );
endinterface

// File: rtl/dram_queue_ptr_mgr_ptr_wrap.sv
// Combinational ring-pointer advance: ptr + len folded back into the inclusive
// window [lo, hi]. Callers guarantee len never exceeds the window size.
module dram_ptr_wrap #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] lo,
  input  logic [ADDR_WIDTH-1:0] hi,
  output logic [ADDR_WIDTH-1:0] next_ptr
);
  localparam int UW = ADDR_WIDTH + 1;

  logic [UW-1:0] size;
  logic [UW-1:0] sum;
  logic [UW-1:0] wrapped;
  logic          wrap_unused;

  // One extra bit so a full 2^ADDR window and ptr+len overflow are representable.
  assign size    = {1'b0, hi} - {1'b0, lo} + UW'(1);
  assign sum     = {1'b0, ptr} + UW'(len);
  assign wrapped = (sum > {1'b0, hi}) ? (sum - size) : sum;
  assign {wrap_unused, next_ptr} = wrapped;

endmodule

// File: rtl/dram_queue_ptr_mgr.sv
// Per-queue DRAM ring-buffer pointer manager: arbitrates store/remove requests,
// checks window space/occupancy and hands out block addresses.
module dram_queue_ptr_mgr
  import dram_queue_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int QID_WIDTH         = 3,
  parameter int ADDR_WIDTH        = 32,
  parameter int LEN_WIDTH         = 11
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  dram_queue_ptr_mgr_if.slave                   req_if,
  input  logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] block_addr_lo,
  input  logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] block_addr_hi,
  input  logic [32*NUM_OUTPUT_QUEUES-1:0]       ctrl,
  output logic [32*NUM_OUTPUT_QUEUES-1:0]       wr_addr,
  output logic [32*NUM_OUTPUT_QUEUES-1:0]       rd_addr,
  output logic [NUM_OUTPUT_QUEUES-1:0]          pkts_stored,
  output logic [NUM_OUTPUT_QUEUES-1:0]          pkts_dropped,
  output logic [NUM_OUTPUT_QUEUES-1:0]          pkts_removed
);
  localparam int N  = NUM_OUTPUT_QUEUES;
  localparam int AW = ADDR_WIDTH;
  localparam int UW = ADDR_WIDTH + 1;

  // Per-queue registered state
  logic [AW-1:0] wr_ptr_reg  [N];
  logic [AW-1:0] rd_ptr_reg  [N];
  logic [UW-1:0] used_reg    [N];
  logic [AW-1:0] lo_copy_reg [N];
  logic [AW-1:0] hi_copy_reg [N];

  logic [AW-1:0] lo_q [N];
  logic [AW-1:0] hi_q [N];
  logic [N-1:0]  reinit;
  logic          ctrl_unused;

  // Control / transaction state
  state_t                state_reg, state_next;
  op_t                   op_reg;
  logic [QID_WIDTH-1:0]  qid_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic                  last_wr_reg;
  logic                  init_pending_reg;

  logic [AW-1:0] cur_wr_ptr_reg, cur_rd_ptr_reg, cur_lo_reg, cur_hi_reg;
  logic [UW-1:0] cur_used_reg;

  logic          grant_wr, grant_rd;
  logic [AW-1:0] wr_ptr_adv, rd_ptr_adv;
  logic [UW-1:0] cur_size, len_ext;
  logic          win_valid, wr_ok, rd_ok;
  logic          in_commit, discard;
  logic          wr_commit, rd_commit;
  logic [N-1:0]  qid_mask;

  assign ctrl_unused = ^ctrl;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_queue
      assign lo_q[gi] = block_addr_lo[gi*AW +: AW];
      assign hi_q[gi] = block_addr_hi[gi*AW +: AW];
      // A window edit by software is treated exactly like an explicit QUEUE_INIT.
      assign reinit[gi] = init_pending_reg
                        | ctrl[gi*32 + CTRL_QUEUE_INIT_BIT]
                        | (lo_q[gi] != lo_copy_reg[gi])
                        | (hi_q[gi] != hi_copy_reg[gi]);
      assign wr_addr[gi*32 +: 32] = 32'(wr_ptr_reg[gi]);
      assign rd_addr[gi*32 +: 32] = 32'(rd_ptr_reg[gi]);
    end
  endgenerate

  // Next-state and arbitration
  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_if.wr_req && (!req_if.rd_req || !last_wr_reg)) begin
          grant_wr = 1'b1;
        end else if (req_if.rd_req) begin
          grant_rd = 1'b1;
        end
        if (grant_wr || grant_rd) begin
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  dram_ptr_wrap #(.ADDR_WIDTH(AW), .LEN_WIDTH(LEN_WIDTH)) u_wr_wrap (
    .ptr      (cur_wr_ptr_reg),
    .len      (len_reg),
    .lo       (cur_lo_reg),
    .hi       (cur_hi_reg),
    .next_ptr (wr_ptr_adv)
  );

  dram_ptr_wrap #(.ADDR_WIDTH(AW), .LEN_WIDTH(LEN_WIDTH)) u_rd_wrap (
    .ptr      (cur_rd_ptr_reg),
    .len      (len_reg),
    .lo       (cur_lo_reg),
    .hi       (cur_hi_reg),
    .next_ptr (rd_ptr_adv)
  );

  // Commit decision
  always_comb begin
    cur_size  = {1'b0, cur_hi_reg} - {1'b0, cur_lo_reg} + UW'(1);
    len_ext   = UW'(len_reg);
    win_valid = (cur_hi_reg >= cur_lo_reg);
    wr_ok     = (len_reg != '0) && win_valid && ((cur_used_reg + len_ext) <= cur_size);
    rd_ok     = (cur_used_reg != '0) && (len_reg != '0) && (len_ext <= cur_used_reg);
    in_commit = (state_reg == ST_COMMIT);
    discard   = reinit[qid_reg];
    wr_commit = in_commit && (op_reg == OP_WR) && wr_ok && !discard;
    rd_commit = in_commit && (op_reg == OP_RD) && rd_ok && !discard;
    qid_mask  = N'(1) << qid_reg;
  end

  assign req_if.wr_ack   = wr_commit;
  assign req_if.wr_drop  = in_commit && (op_reg == OP_WR) && !wr_commit;
  assign req_if.wr_base  = cur_wr_ptr_reg;
  assign req_if.rd_ack   = rd_commit;
  assign req_if.rd_empty = in_commit && (op_reg == OP_RD) && !rd_commit;
  assign req_if.rd_base  = cur_rd_ptr_reg;

  assign pkts_stored  = wr_commit ? qid_mask : '0;
  assign pkts_dropped = req_if.wr_drop ? qid_mask : '0;
  assign pkts_removed = rd_commit ? qid_mask : '0;

  // FSM, latched request and looked-up queue snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      op_reg           <= OP_WR;
      qid_reg          <= '0;
      len_reg          <= '0;
      last_wr_reg      <= 1'b0;
      init_pending_reg <= 1'b1;
      cur_wr_ptr_reg   <= '0;
      cur_rd_ptr_reg   <= '0;
      cur_used_reg     <= '0;
      cur_lo_reg       <= '0;
      cur_hi_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      init_pending_reg <= 1'b0;
      if (grant_wr || grant_rd) begin
        op_reg      <= grant_wr ? OP_WR : OP_RD;
        qid_reg     <= grant_wr ? req_if.wr_qid : req_if.rd_qid;
        len_reg     <= grant_wr ? req_if.wr_len : req_if.rd_len;
        last_wr_reg <= grant_wr;
      end
      if (state_reg == ST_LOOKUP) begin
        cur_lo_reg <= lo_q[qid_reg];
        cur_hi_reg <= hi_q[qid_reg];
        // Snapshot the post-init view if the queue is being re-initialised this cycle.
        if (reinit[qid_reg]) begin
          cur_wr_ptr_reg <= lo_q[qid_reg];
          cur_rd_ptr_reg <= lo_q[qid_reg];
          cur_used_reg   <= '0;
        end else begin
          cur_wr_ptr_reg <= wr_ptr_reg[qid_reg];
          cur_rd_ptr_reg <= rd_ptr_reg[qid_reg];
          cur_used_reg   <= used_reg[qid_reg];
        end
      end
    end
  end

  // Per-queue pointer state; re-init takes priority over a commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int q = 0; q < N; q++) begin
        wr_ptr_reg[q]  <= '0;
        rd_ptr_reg[q]  <= '0;
        used_reg[q]    <= '0;
        lo_copy_reg[q] <= '0;
        hi_copy_reg[q] <= '0;
      end
    end else begin
      for (int q = 0; q < N; q++) begin
        if (reinit[q]) begin
          wr_ptr_reg[q]  <= lo_q[q];
          rd_ptr_reg[q]  <= lo_q[q];
          used_reg[q]    <= '0;
          lo_copy_reg[q] <= lo_q[q];
          hi_copy_reg[q] <= hi_q[q];
        end else if (wr_commit && qid_mask[q]) begin
          wr_ptr_reg[q] <= wr_ptr_adv;
          used_reg[q]   <= cur_used_reg + len_ext;
        end else if (rd_commit && qid_mask[q]) begin
          rd_ptr_reg[q] <= rd_ptr_adv;
          used_reg[q]   <= cur_used_reg - len_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_queue_ptr_mgr.sv
// Scoreboard bench for dram_queue_ptr_mgr: directed scenarios plus random traffic
// checked against a ring-buffer model built on modulo arithmetic.
module tb_dram_queue_ptr_mgr;
  localparam int NQ = 8;

  logic clk;
  logic reset_n;
  logic [32*NQ-1:0] lo_flat, hi_flat, ctrl_flat;
  logic [32*NQ-1:0] wr_addr, rd_addr;
  logic [NQ-1:0]    pkts_stored, pkts_dropped, pkts_removed;
  logic [31:0]      lo_arr [NQ];
  logic [31:0]      hi_arr [NQ];

  dram_queue_ptr_mgr_if #(.QID_WIDTH(3), .ADDR_WIDTH(32), .LEN_WIDTH(11)) ifc ();

  dram_queue_ptr_mgr #(
    .NUM_OUTPUT_QUEUES(NQ), .QID_WIDTH(3), .ADDR_WIDTH(32), .LEN_WIDTH(11)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_if        (ifc),
    .block_addr_lo (lo_flat),
    .block_addr_hi (hi_flat),
    .ctrl          (ctrl_flat),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .pkts_stored   (pkts_stored),
    .pkts_dropped  (pkts_dropped),
    .pkts_removed  (pkts_removed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    lo_flat = '0;
    hi_flat = '0;
    for (int q = 0; q < NQ; q++) begin
      lo_flat[q*32 +: 32] = lo_arr[q];
      hi_flat[q*32 +: 32] = hi_arr[q];
    end
  end

  typedef struct {
    bit     is_wr;
    bit     ok;
    int     qid;
    longint base;
    longint wr_ptr;
    longint rd_ptr;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint m_wr [NQ];
  longint m_rd [NQ];
  longint m_used [NQ];
  bit     m_last_wr;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset_q(int q);
    m_wr[q]   = lo_arr[q];
    m_rd[q]   = lo_arr[q];
    m_used[q] = 0;
  endfunction

  function automatic void model_reset_all();
    for (int q = 0; q < NQ; q++) model_reset_q(q);
    m_last_wr = 1'b0;
  endfunction

  // Ring buffer of 'size' blocks starting at lo; pointer advance is lo + (offset+len) mod size.
  function automatic void model_txn(bit is_wr, int q, int len, output exp_t e);
    longint lo   = lo_arr[q];
    longint hi   = hi_arr[q];
    longint size = hi - lo + 1;
    e.is_wr = is_wr;
    e.qid   = q;
    e.ok    = 1'b0;
    e.base  = 0;
    if (is_wr) begin
      if (len != 0 && hi >= lo && m_used[q] + len <= size) begin
        e.ok      = 1'b1;
        e.base    = m_wr[q];
        m_wr[q]   = lo + ((m_wr[q] - lo + len) % size);
        m_used[q] = m_used[q] + len;
      end
    end else begin
      if (m_used[q] != 0 && len != 0 && len <= m_used[q]) begin
        e.ok      = 1'b1;
        e.base    = m_rd[q];
        m_rd[q]   = lo + ((m_rd[q] - lo + len) % size);
        m_used[q] = m_used[q] - len;
      end
    end
    e.wr_ptr  = m_wr[q];
    e.rd_ptr  = m_rd[q];
    m_last_wr = is_wr;
  endfunction

  function automatic bit pulse_any();
    return ifc.wr_ack | ifc.wr_drop | ifc.rd_ack | ifc.rd_empty;
  endfunction

  // Waits for n handshake pulses, then returns 1ns into the following cycle.
  task automatic wait_pulses(int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (pulse_any()) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got %0d pulses expected %0d", seen, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(bit is_wr, int q, int len);
    exp_t e;
    model_txn(is_wr, q, len, e);
    exp_q.push_back(e);
    if (is_wr) begin
      ifc.wr_req = 1'b1;
      ifc.wr_qid = 3'(q);
      ifc.wr_len = 11'(len);
    end else begin
      ifc.rd_req = 1'b1;
      ifc.rd_qid = 3'(q);
      ifc.rd_len = 11'(len);
    end
    wait_pulses(1);
    ifc.wr_req = 1'b0;
    ifc.rd_req = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake pulse
  initial begin
    exp_t e;
    logic [3:0] exp_pulse;
    logic [NQ-1:0] qmask;
    forever begin
      @(negedge clk);
      if (pulse_any()) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got wr_ack=%0b wr_drop=%0b rd_ack=%0b rd_empty=%0b expected none",
                   ifc.wr_ack, ifc.wr_drop, ifc.rd_ack, ifc.rd_empty);
        end else begin
          e = exp_q.pop_front();
          exp_pulse = e.is_wr ? (e.ok ? 4'b1000 : 4'b0100) : (e.ok ? 4'b0010 : 4'b0001);
          qmask = NQ'(1) << e.qid;
          $display("txn q%0d %s len-check ok=%0b base=%0d", e.qid, e.is_wr ? "WR" : "RD", e.ok, e.base);
          chk("pulse_kind", {ifc.wr_ack, ifc.wr_drop, ifc.rd_ack, ifc.rd_empty}, exp_pulse);
          if (e.ok && e.is_wr)  chk("wr_base", ifc.wr_base, e.base);
          if (e.ok && !e.is_wr) chk("rd_base", ifc.rd_base, e.base);
          chk("pkts_stored",  pkts_stored,  (e.is_wr && e.ok)   ? qmask : '0);
          chk("pkts_dropped", pkts_dropped, (e.is_wr && !e.ok)  ? qmask : '0);
          chk("pkts_removed", pkts_removed, (!e.is_wr && e.ok)  ? qmask : '0);
          @(negedge clk);
          chk("pulse_one_cycle", pulse_any(), 0);
          chk("wr_addr", wr_addr[e.qid*32 +: 32], e.wr_ptr);
          chk("rd_addr", rd_addr[e.qid*32 +: 32], e.rd_ptr);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, len;
    exp_t e;
    reset_n    = 1'b0;
    ctrl_flat  = '0;
    ifc.wr_req = 1'b0; ifc.wr_qid = '0; ifc.wr_len = '0;
    ifc.rd_req = 1'b0; ifc.rd_qid = '0; ifc.rd_len = '0;
    lo_arr[0] = 0;    hi_arr[0] = 1023;
    lo_arr[1] = 1024; hi_arr[1] = 1039;
    lo_arr[2] = 1040; hi_arr[2] = 1103;
    lo_arr[3] = 2048; hi_arr[3] = 2063;
    lo_arr[4] = 4096; hi_arr[4] = 4195;
    lo_arr[5] = 5000; hi_arr[5] = 5030;
    lo_arr[6] = 6000; hi_arr[6] = 6006;
    lo_arr[7] = 7000; hi_arr[7] = 6999;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pulses", pulse_any(), 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset_all();

    // q0 wide window, then shrink to 16 blocks and fill exactly
    run_txn(1, 0, 10);
    hi_arr[0] = 15;
    model_reset_q(0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resize_reinit_wr_addr", wr_addr[0 +: 32], 0);
    @(posedge clk); #1;
    run_txn(1, 0, 10);
    run_txn(1, 0, 6);
    run_txn(1, 0, 1);

    // q1 wrapping grant
    run_txn(1, 1, 12);
    run_txn(0, 1, 12);
    run_txn(1, 1, 8);

    // q2 occupancy limits
    run_txn(0, 2, 3);
    run_txn(1, 2, 4);
    run_txn(0, 2, 5);
    run_txn(0, 2, 0);
    run_txn(0, 2, 4);

    // q3 both requests held: grants must alternate
    for (int k = 0; k < 6; k++) begin
      if (m_last_wr) model_txn(0, 3, 2, e);
      else           model_txn(1, 3, 3, e);
      exp_q.push_back(e);
    end
    ifc.wr_req = 1'b1; ifc.wr_qid = 3'd3; ifc.wr_len = 11'd3;
    ifc.rd_req = 1'b1; ifc.rd_qid = 3'd3; ifc.rd_len = 11'd2;
    wait_pulses(6);
    ifc.wr_req = 1'b0;
    ifc.rd_req = 1'b0;

    // q4 software init with data outstanding
    run_txn(1, 4, 3);
    run_txn(1, 4, 4);
    ctrl_flat[4*32] = 1'b1;
    @(posedge clk); #1;
    ctrl_flat[4*32] = 1'b0;
    model_reset_q(4);
    @(negedge clk);
    chk("init_wr_addr", wr_addr[4*32 +: 32], lo_arr[4]);
    chk("init_rd_addr", rd_addr[4*32 +: 32], lo_arr[4]);
    @(posedge clk); #1;
    run_txn(0, 4, 1);
    run_txn(1, 4, 5);

    // Random traffic on q2, q5, q6 (tiny window) and q7 (invalid window)
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: q = 2;
        1: q = 5;
        2: q = 6;
        default: q = 7;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        run_txn(1, q, $urandom_range(0, 10));
      end else begin
        len = $urandom_range(0, int'(m_used[q]) + 2);
        run_txn(0, q, len);
      end
    end

    // Reset while a write sits in LOOKUP: it must vanish without a pulse
    ifc.wr_req = 1'b1; ifc.wr_qid = 3'd0; ifc.wr_len = 11'd3;
    @(posedge clk); #1;
    reset_n    = 1'b0;
    ifc.wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset_all();
    @(negedge clk);
    chk("post_reset_q5_wr_addr", wr_addr[5*32 +: 32], lo_arr[5]);
    @(posedge clk); #1;
    run_txn(1, 0, 5);
    run_txn(0, 0, 5);

    repeat (5) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
